strip_conv_scheduler: RTL and testbench

- Frame-level controller for the segmented-frame convolution path. It gates frame processing on kernel load completion, resets and launches NUM_STRIPS horizontal-strip im2col convolution units in parallel, and waits for all of them with a timeout.
- It then reads every unit's result BRAM in strip order, sharing the single address bus, and streams the results out on one valid/ready port.

---
 rtl/strip_conv_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_strip_conv_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/strip_conv_scheduler.sv
// strip_conv_scheduler: frame-level controller for the segmented-frame
// convolution path. It waits for the kernel load, resets and launches every
// strip unit together, collects their done flags under a timeout, then reads
// every unit's result BRAM in strip order over one shared address bus and
// streams the words out on a single valid/ready port.
module strip_conv_scheduler #(
  parameter int NUM_STRIPS  = 8,
  parameter int SEL_W       = 3,
  parameter int DATA_W      = 23,
  parameter int ADDR_W      = 13,
  parameter int STRIP_LEN   = 6216,
  parameter int READ_LAT    = 3,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic                          kernel_read_complete,
  output logic                          unit_rst,
  output logic [NUM_STRIPS-1:0]         unit_start,
  input  logic [NUM_STRIPS-1:0]         unit_done,
  output logic [ADDR_W-1:0]             unit_addr,
  input  logic [NUM_STRIPS*DATA_W-1:0]  unit_out,
  output logic signed [DATA_W-1:0]      m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [SEL_W-1:0]              m_strip,
  output logic                          m_strip_last,
  output logic                          m_last,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          error
);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_WAIT_KERNEL = 4'd1;
  localparam logic [3:0] S_UNIT_RESET  = 4'd2;
  localparam logic [3:0] S_LAUNCH      = 4'd3;
  localparam logic [3:0] S_WAIT_DONE   = 4'd4;
  localparam logic [3:0] S_RD_ADDR     = 4'd5;
  localparam logic [3:0] S_RD_WAIT     = 4'd6;
  localparam logic [3:0] S_RD_OUT      = 4'd7;
  localparam logic [3:0] S_FRAME_DONE  = 4'd8;
  localparam logic [3:0] S_ERROR       = 4'd9;

  // One shared down-time counter serves both the unit reset pulse and the
  // BRAM read latency, so it is sized for the larger of the two.
  localparam int CNT_MAX = (RST_CYC > READ_LAT) ? RST_CYC : READ_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TCNT_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]  RL_LAST    = CNT_W'(READ_LAT - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX   = TCNT_W'(TIMEOUT_CYC);
  localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(STRIP_LEN - 1);
  localparam logic [SEL_W-1:0]  LAST_STRIP = SEL_W'(NUM_STRIPS - 1);

  logic [3:0]            state;
  logic [3:0]            next_state;
  logic [CNT_W-1:0]      cnt;
  logic [TCNT_W-1:0]     tcnt;
  logic [NUM_STRIPS-1:0] done_seen;
  logic                  done_all;
  logic                  timeout_hit;

  // Pick strip sel's word out of the concatenated result bus. Constant
  // slices keep the mux in range for any NUM_STRIPS.
  function automatic logic signed [DATA_W-1:0] strip_word(
    input logic [NUM_STRIPS*DATA_W-1:0] bus,
    input logic [SEL_W-1:0]             sel
  );
    logic signed [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_STRIPS; k++) begin
      if (sel == SEL_W'(k)) w = bus[k*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  // The current cycle's done pulses count, so a unit finishing on the
  // deciding cycle is not lost.
  assign done_all    = &(done_seen | unit_done);
  assign timeout_hit = (tcnt >= TCNT_LAST);

  // Next-state decode for the frame sequence.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:        if (frame_start) next_state = S_WAIT_KERNEL;
      S_WAIT_KERNEL: if (kernel_read_complete) next_state = S_UNIT_RESET;
      S_UNIT_RESET:  if (cnt == RST_LAST) next_state = S_LAUNCH;
      S_LAUNCH:      next_state = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done_all) next_state = S_RD_ADDR;
        else if (timeout_hit) next_state = S_ERROR;
      end
      S_RD_ADDR:     next_state = S_RD_WAIT;
      S_RD_WAIT:     if (cnt == RL_LAST) next_state = S_RD_OUT;
      S_RD_OUT: begin
        if (m_valid && m_ready) next_state = m_last ? S_FRAME_DONE : S_RD_ADDR;
      end
      S_FRAME_DONE:  next_state = S_IDLE;
      S_ERROR:       if (frame_start) next_state = S_WAIT_KERNEL;
      default:       next_state = S_IDLE;
    endcase
  end

  // State register, dwell counter, timeout counter and done capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      done_seen <= '0;
    end else begin
      state <= next_state;
      if ((state == S_UNIT_RESET || state == S_RD_WAIT) && next_state == state)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      case (state)
        S_UNIT_RESET: begin
          done_seen <= '0;
          tcnt      <= '0;
        end
        S_WAIT_DONE: begin
          done_seen <= done_seen | unit_done;
          if (!done_all && tcnt != TCNT_MAX) tcnt <= tcnt + TCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      unit_rst   <= 1'b1;
      unit_start <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      unit_rst   <= (next_state == S_UNIT_RESET) || (next_state == S_ERROR);
      unit_start <= (next_state == S_LAUNCH || next_state == S_WAIT_DONE) ? '1 : '0;
      busy       <= !(next_state == S_IDLE || next_state == S_ERROR);
      frame_done <= (next_state == S_FRAME_DONE);
      error      <= (next_state == S_ERROR);
    end
  end

  // Readout: the address/strip registers double as the walk counters and
  // change on entry to RD_ADDR, giving the BRAM the full read latency before
  // the word is captured on the last RD_WAIT cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      unit_addr    <= '0;
      m_strip      <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_strip_last <= 1'b0;
      m_last       <= 1'b0;
    end else begin
      if (state == S_WAIT_DONE && next_state == S_RD_ADDR) begin
        unit_addr <= '0;
        m_strip   <= '0;
      end
      if (state == S_RD_WAIT && next_state == S_RD_OUT) begin
        m_data       <= strip_word(unit_out, m_strip);
        m_valid      <= 1'b1;
        m_strip_last <= (unit_addr == LAST_ADDR);
        m_last       <= (unit_addr == LAST_ADDR) && (m_strip == LAST_STRIP);
      end
      if (state == S_RD_OUT && m_valid && m_ready) begin
        m_valid <= 1'b0;
        if (!m_last) begin
          if (m_strip_last) begin
            m_strip   <= m_strip + SEL_W'(1);
            unit_addr <= '0;
          end else begin
            unit_addr <= unit_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_strip_conv_scheduler.sv
// Directed bench for strip_conv_scheduler: two strips of four results, a
// three-cycle BRAM model, and hand-computed beat tables.
module tb_strip_conv_scheduler;

  localparam int NS  = 2;
  localparam int SW  = 1;
  localparam int DW  = 23;
  localparam int AW  = 13;
  localparam int SL  = 4;
  localparam int RL  = 3;
  localparam int RC  = 2;
  localparam int TO  = 50;

  logic              clk;
  logic              reset_n;
  logic              frame_start;
  logic              kernel_read_complete;
  logic              unit_rst;
  logic [NS-1:0]     unit_start;
  logic [NS-1:0]     unit_done;
  logic [AW-1:0]     unit_addr;
  logic [NS*DW-1:0]  unit_out;
  logic signed [DW-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [SW-1:0]     m_strip;
  logic              m_strip_last;
  logic              m_last;
  logic              busy;
  logic              frame_done;
  logic              error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int stall;
    int data;
    int strip;
    bit slast;
    bit last;
  } vec_t;

  vec_t vec [8];

  strip_conv_scheduler #(
    .NUM_STRIPS(NS), .SEL_W(SW), .DATA_W(DW), .ADDR_W(AW),
    .STRIP_LEN(SL), .READ_LAT(RL), .RST_CYC(RC), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .kernel_read_complete(kernel_read_complete), .unit_rst(unit_rst),
    .unit_start(unit_start), .unit_done(unit_done), .unit_addr(unit_addr),
    .unit_out(unit_out), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_strip(m_strip), .m_strip_last(m_strip_last),
    .m_last(m_last), .busy(busy), .frame_done(frame_done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: unit k returns k*100 + addr, RL register stages behind unit_addr.
  logic [AW-1:0] a1, a2, a3;
  always @(posedge clk) begin
    a1 <= unit_addr;
    a2 <= a1;
    a3 <= a2;
  end
  assign unit_out = {DW'(32'd100 + 32'(a3)), DW'(a3)};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Wait for the unit reset pulse, measure its length, confirm launch.
  task automatic reset_and_launch();
    int w;
    int rc;
    w = 0;
    while (unit_rst !== 1'b1 && w < 40) begin step(); w++; end
    check("rst_seen", unit_rst, 1);
    rc = 0;
    while (unit_rst === 1'b1 && rc < 10) begin
      check("rst_start_low", unit_start, 0);
      step();
      rc++;
    end
    check("rst_len", rc, RC);
    check("launch_start", unit_start, 2'b11);
    check("launch_busy", busy, 1);
  endtask

  // Pulse each done bit once, d0/d1 cycles after the launch cycle.
  task automatic pulse_done(input int d0, input int d1);
    int md;
    md = (d0 > d1) ? d0 : d1;
    for (int t = 1; t <= md; t++) begin
      unit_done = {(t == d1), (t == d0)};
      step();
      if (t < md) check("start_held", unit_start, 2'b11);
    end
    unit_done = 2'b00;
    check("start_drop", unit_start, 0);
    check("rd_busy", busy, 1);
    check("rd_no_valid", m_valid, 0);
  endtask

  task automatic run_readout(input int nbeats, input bit use_stall);
    int w;
    int st;
    for (int i = 0; i < nbeats; i++) begin
      st = use_stall ? vec[i].stall : 0;
      m_ready = (st == 0);
      w = 0;
      while (m_valid !== 1'b1 && w < 20) begin step(); w++; end
      check("beat_gap", w, RL + 1);
      if (st > 0) begin
        for (int s = 1; s < st; s++) begin
          step();
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, vec[i].data);
        end
        m_ready = 1'b1;
      end
      check("beat_data", m_data, vec[i].data);
      check("beat_strip", m_strip, vec[i].strip);
      check("beat_slast", m_strip_last, vec[i].slast);
      check("beat_last", m_last, vec[i].last);
      step();
      check("accept_drop", m_valid, 0);
    end
  endtask

  task automatic frame_end();
    check("fd_pulse", {frame_done, busy}, 2'b11);
    step();
    check("fd_after", {frame_done, busy, m_valid}, 3'b000);
  endtask

  initial begin
    int n;
    int g;
    vec[0] = '{0,   0, 0, 1'b0, 1'b0};
    vec[1] = '{0,   1, 0, 1'b0, 1'b0};
    vec[2] = '{5,   2, 0, 1'b0, 1'b0};
    vec[3] = '{0,   3, 0, 1'b1, 1'b0};
    vec[4] = '{0, 100, 1, 1'b0, 1'b0};
    vec[5] = '{0, 101, 1, 1'b0, 1'b0};
    vec[6] = '{0, 102, 1, 1'b0, 1'b0};
    vec[7] = '{0, 103, 1, 1'b1, 1'b1};

    reset_n = 1'b0;
    frame_start = 1'b0;
    kernel_read_complete = 1'b0;
    unit_done = 2'b00;
    m_ready = 1'b1;
    step();
    step();
    check("rst_unit_rst", unit_rst, 1);
    check("rst_outputs", {unit_start, m_valid, busy, frame_done, error}, 0);
    check("rst_data", {unit_addr, m_data, m_strip, m_strip_last, m_last}, 0);
    reset_n = 1'b1;
    step();
    check("idle_unit_rst", unit_rst, 0);

    // Nominal frame
    kernel_read_complete = 1'b1;
    start_frame();
    check("wk_busy", busy, 1);
    reset_and_launch();
    pulse_done(10, 10);
    run_readout(8, 1'b0);
    frame_end();

    // Backpressure on beat 2
    start_frame();
    reset_and_launch();
    pulse_done(3, 3);
    run_readout(8, 1'b1);
    frame_end();

    // Kernel gating
    kernel_read_complete = 1'b0;
    start_frame();
    for (int c = 0; c < 20; c++) begin
      check("kgate", {busy, unit_rst, unit_start}, 4'b1000);
      step();
    end
    kernel_read_complete = 1'b1;
    reset_and_launch();
    pulse_done(2, 2);
    run_readout(8, 1'b0);
    frame_end();

    // Staggered done pulses
    start_frame();
    reset_and_launch();
    pulse_done(5, 12);
    run_readout(8, 1'b0);
    frame_end();

    // Timeout: unit 1 never finishes
    start_frame();
    reset_and_launch();
    n = 0;
    g = 0;
    while (error !== 1'b1 && g < 100) begin
      if (unit_start == 2'b11) n++;
      unit_done = (g == 3) ? 2'b01 : 2'b00;
      step();
      g++;
    end
    unit_done = 2'b00;
    check("to_cycles", n, TO + 1);
    check("to_flags", {error, unit_rst, busy, m_valid, unit_start}, 6'b110000);
    step();
    step();
    step();
    check("to_sticky", {error, unit_rst, busy}, 3'b110);
    start_frame();
    check("to_clear", {error, busy}, 2'b01);
    reset_and_launch();
    pulse_done(4, 4);
    run_readout(8, 1'b0);
    frame_end();

    // Reset while beat 101 is pending
    start_frame();
    reset_and_launch();
    pulse_done(6, 6);
    run_readout(5, 1'b0);
    m_ready = 1'b0;
    g = 0;
    while (m_valid !== 1'b1 && g < 20) begin step(); g++; end
    check("pend_data", m_data, 101);
    step();
    check("pend_hold", {m_valid, m_data}, {1'b1, 23'd101});
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mid_rst", {m_valid, unit_start, busy, unit_rst}, 5'b00001);
    m_ready = 1'b1;
    step();
    check("mid_idle", {unit_rst, busy}, 2'b00);
    start_frame();
    reset_and_launch();
    pulse_done(3, 3);
    run_readout(8, 1'b0);
    frame_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
